// File: rtl/nasti_arb_pkg.sv
// -----------------------------------------------------------------------------
// nasti_arb_pkg
// Shared definitions for the NASTI address-channel arbiters.
//   NASTI_ARB_MAX_PORTS : largest supported requester count
//   arb_state_t         : arbiter FSM encoding (idle / grant held)
//   onehot_to_idx       : one-hot to binary index conversion
// -----------------------------------------------------------------------------
package nasti_arb_pkg;

  localparam int NASTI_ARB_MAX_PORTS = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // OR together the indices of all set bits; exact for a one-hot input.
  function automatic logic [2:0] onehot_to_idx(input logic [NASTI_ARB_MAX_PORTS-1:0] i_oh);
    logic [2:0] v_idx;
    v_idx = 3'd0;
    for (int i = 0; i < NASTI_ARB_MAX_PORTS; i++) begin
      v_idx = v_idx | (i_oh[i] ? 3'(i) : 3'd0);
    end
    return v_idx;
  endfunction

endpackage

// File: rtl/nasti_rr_pick.sv
// -----------------------------------------------------------------------------
// nasti_rr_pick
// Combinational round-robin picker: selects the first set bit of the eligible
// mask at or after the start position, wrapping from N-1 back to 0.
// Ports:
//   i_eligible [N]  : candidate mask
//   i_start    [IW] : search start position (always < N)
//   o_found         : at least one candidate was set
//   o_onehot   [N]  : one-hot winner (zero when nothing found)
//   o_idx      [IW] : binary index of the winner
// -----------------------------------------------------------------------------
module nasti_rr_pick
  import nasti_arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx
);

  logic [NASTI_ARB_MAX_PORTS-1:0] w_oh_pad;
  logic [2:0]                     w_idx_full;

  // Winner is the eligible port with the smallest wrapped distance from the start.
  always_comb begin
    int   v_best;
    int   v_best_dist;
    int   v_dist;
    logic v_take;
    v_best      = 0;
    v_best_dist = N;
    v_dist      = 0;
    v_take      = 1'b0;
    for (int j = 0; j < N; j++) begin
      v_dist      = (j >= int'(i_start)) ? (j - int'(i_start)) : (j + N - int'(i_start));
      v_take      = i_eligible[j] && (v_dist < v_best_dist);
      v_best_dist = v_take ? v_dist : v_best_dist;
      v_best      = v_take ? j : v_best;
    end
    o_found = (v_best_dist < N);
    for (int j = 0; j < N; j++) begin
      o_onehot[j] = o_found && (v_best == j);
    end
  end

  // Binary index derived from the one-hot winner.
  always_comb begin
    w_oh_pad          = {NASTI_ARB_MAX_PORTS{1'b0}};
    w_oh_pad[N-1:0]   = o_onehot;
    w_idx_full        = onehot_to_idx(w_oh_pad);
    o_idx             = w_idx_full[IW-1:0];
  end

endmodule

// File: rtl/nasti_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// nasti_wrr_arbiter
// Weighted round-robin arbiter sharing one NASTI AW or AR master channel among
// N slave ports. The grant is registered, one-hot, and held until the address
// handshake completes or the granted request is withdrawn. Each port owns a
// credit counter reloaded to weight+1 when no requesting port has credit left.
//
// Optional build macro: NASTI_WRR_AGE_EN
//   Adds per-port age counters; a port that has watched AGE_LIMIT handshakes
//   of other ports while requesting wins the next pick without spending credit.
//
// Ports:
//   clk        : clock
//   rstn       : asynchronous active-low reset
//   req   [N]  : per-port request (s.aw_valid / s.ar_valid vector)
//   weight[N*W_WIDTH] : packed weights, port i at [i*W_WIDTH +: W_WIDTH]
//   enable     : allows new grants
//   ack        : handshake of the granted request (m.valid && m.ready)
//   gnt   [N]  : one-hot grant
//   gnt_idx    : binary index of gnt
//   gnt_valid  : gnt is meaningful
// -----------------------------------------------------------------------------
module nasti_wrr_arbiter
  import nasti_arb_pkg::*;
#(
  parameter int N         = 8,
  parameter int W_WIDTH   = 4,
  parameter int AGE_LIMIT = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [N-1:0]                      req,
  input  logic [N*W_WIDTH-1:0]              weight,
  input  logic                              enable,
  input  logic                              ack,
  output logic [N-1:0]                      gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
  output logic                              gnt_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = W_WIDTH + 1;
  localparam logic [CW-1:0] CREDIT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);
  localparam logic [N-1:0]  ZERO_N      = {N{1'b0}};

  arb_state_t    r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_ptr_post, w_ptr_nxt, w_ptr_inc;
  logic [CW-1:0] r_credit      [N];
  logic [CW-1:0] w_credit_post [N];
  logic [CW-1:0] w_credit_nxt  [N];
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [IW-1:0] r_gnt_idx, w_gnt_idx_nxt;
  logic          r_gnt_valid, w_gnt_valid_nxt;

  logic          w_ack, w_spent, w_held_req, w_pick_try, w_pick_go;
  logic          w_reload, w_urgent_any, w_cur_urgent;
  logic [N-1:0]  w_pick_req, w_elig_cr, w_urgent_mask, w_pick_mask, w_pick_oh;
  logic [IW-1:0] w_pick_start, w_pick_idx;
  logic          w_pick_found;

  // Settle the current handshake: spend credit, move the pointer, build the request set.
  always_comb begin
    w_ack      = (r_state == ARB_GRANT) && r_gnt_valid && ack;
    w_held_req = req[r_gnt_idx];
    for (int i = 0; i < N; i++) begin
      w_credit_post[i] = (w_ack && !w_cur_urgent && r_gnt[i] && (r_credit[i] != CREDIT_ZERO))
                         ? (r_credit[i] - CREDIT_ONE) : r_credit[i];
    end
    w_spent = w_ack;
    for (int i = 0; i < N; i++) begin
      w_spent = w_spent && !(r_gnt[i] && (w_credit_post[i] != CREDIT_ZERO));
    end
    w_ptr_inc  = (r_gnt_idx == IW'(N - 1)) ? {IW{1'b0}} : (r_gnt_idx + IW'(1));
    w_ptr_post = (w_ack && !w_cur_urgent) ? (w_spent ? w_ptr_inc : r_gnt_idx) : r_ptr;
    // A port that just spent its last credit sits out the same-cycle pick so it
    // cannot force a reload on its own; with credit left it keeps priority.
    if (r_state == ARB_IDLE) begin
      w_pick_req = req;
    end else if (w_ack) begin
      w_pick_req = req & ~(w_spent ? r_gnt : ZERO_N);
    end else begin
      w_pick_req = ZERO_N;
    end
    w_pick_try = enable && ((r_state == ARB_IDLE) || w_ack) && (w_pick_req != ZERO_N);
  end

  // Choose the picker inputs: urgent ports first, then credited ports, else reload.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_elig_cr[i] = w_pick_req[i] && (w_credit_post[i] != CREDIT_ZERO);
    end
    w_urgent_any = (w_urgent_mask != ZERO_N);
    w_reload     = !w_urgent_any && (w_elig_cr == ZERO_N);
    w_pick_mask  = w_urgent_any ? w_urgent_mask : (w_reload ? w_pick_req : w_elig_cr);
    w_pick_start = w_urgent_any ? {IW{1'b0}} : w_ptr_post;
  end

  nasti_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_eligible (w_pick_mask),
    .i_start    (w_pick_start),
    .o_found    (w_pick_found),
    .o_onehot   (w_pick_oh),
    .o_idx      (w_pick_idx)
  );

  assign w_pick_go = w_pick_try && w_pick_found;

  // FSM next state, grant, pointer and credit update.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_ptr_nxt       = w_ptr_post;
    for (int i = 0; i < N; i++) begin
      w_credit_nxt[i] = w_credit_post[i];
    end
    if (w_pick_go) begin
      w_state_nxt     = ARB_GRANT;
      w_gnt_nxt       = w_pick_oh;
      w_gnt_idx_nxt   = w_pick_idx;
      w_gnt_valid_nxt = 1'b1;
      for (int i = 0; i < N; i++) begin
        w_credit_nxt[i] = w_reload ? ({1'b0, weight[i*W_WIDTH +: W_WIDTH]} + CREDIT_ONE)
                                   : w_credit_post[i];
      end
    end else begin
      case (r_state)
        ARB_IDLE: begin
          w_state_nxt = ARB_IDLE;
        end
        ARB_GRANT: begin
          // Handshake with nothing to follow, or request withdrawn: drop the grant.
          if (w_ack || !w_held_req) begin
            w_state_nxt     = ARB_IDLE;
            w_gnt_nxt       = ZERO_N;
            w_gnt_idx_nxt   = {IW{1'b0}};
            w_gnt_valid_nxt = 1'b0;
          end else begin
            w_state_nxt = ARB_GRANT;
          end
        end
        default: begin
          w_state_nxt     = ARB_IDLE;
          w_gnt_nxt       = ZERO_N;
          w_gnt_idx_nxt   = {IW{1'b0}};
          w_gnt_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= {IW{1'b0}};
      r_gnt       <= ZERO_N;
      r_gnt_idx   <= {IW{1'b0}};
      r_gnt_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_credit[i] <= CREDIT_ZERO;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      for (int i = 0; i < N; i++) begin
        r_credit[i] <= w_credit_nxt[i];
      end
    end
  end

`ifdef NASTI_WRR_AGE_EN
  localparam int            AGW     = $clog2(AGE_LIMIT + 1);
  localparam logic [AGW-1:0] AGE_MAX = AGW'(AGE_LIMIT);

  logic [AGW-1:0] r_age      [N];
  logic [AGW-1:0] w_age_post [N];
  logic [AGW-1:0] w_age_nxt  [N];
  logic           r_urgent, w_urgent_nxt;

  assign w_cur_urgent = r_urgent;

  // Age requesters on every handshake won by another port; flag those at the limit.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_age_post[i]    = (w_ack && req[i] && !r_gnt[i] && (r_age[i] < AGE_MAX))
                         ? (r_age[i] + AGW'(1)) : r_age[i];
      w_urgent_mask[i] = w_pick_req[i] && (w_age_post[i] >= AGE_MAX);
    end
  end

  // Winner's age restarts; remember whether the live grant bypassed credit.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_age_nxt[i] = (w_pick_go && w_pick_oh[i]) ? {AGW{1'b0}} : w_age_post[i];
    end
    w_urgent_nxt = w_pick_go ? w_urgent_any : (r_urgent && w_gnt_valid_nxt);
  end

  // Age and urgent-grant registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_urgent <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_age[i] <= {AGW{1'b0}};
      end
    end else begin
      r_urgent <= w_urgent_nxt;
      for (int i = 0; i < N; i++) begin
        r_age[i] <= w_age_nxt[i];
      end
    end
  end
`else
  assign w_urgent_mask = ZERO_N;
  assign w_cur_urgent  = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_nasti_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nasti_wrr_arbiter
// Directed self-checking bench for nasti_wrr_arbiter (N=8, W_WIDTH=4,
// AGE_LIMIT=4). Expected grant sequences are worked out by hand from the
// weighted round-robin rules. Honours NASTI_WRR_AGE_EN for the starvation case.
// -----------------------------------------------------------------------------
module tb_nasti_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  req;
  logic [31:0] weight;
  logic        enable;
  logic        ack;
  logic [7:0]  gnt;
  logic [2:0]  gnt_idx;
  logic        gnt_valid;

  int n_pass  = 0;
  int n_total = 0;

  nasti_wrr_arbiter #(
    .N         (8),
    .W_WIDTH   (4),
    .AGE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .weight    (weight),
    .enable    (enable),
    .ack       (ack),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    req    = 8'h00;
    ack    = 1'b0;
    enable = 1'b1;
    weight = 32'h0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn   = 1'b0;
    req    = 8'hFF;
    enable = 1'b1;
    ack    = 1'b0;
    weight = 32'h0;
    #3;
    n_total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0)
      $display("FAIL reset_state: gnt=%h valid=%b idx=%0d expected 00/0/0", gnt, gnt_valid, gnt_idx);
    else n_pass++;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    n_total++;
    if (gnt !== 8'h01 || gnt_valid !== 1'b1)
      $display("FAIL reset_first_grant: gnt=%h valid=%b expected 01/1", gnt, gnt_valid);
    else n_pass++;
    tick();
    n_total++;
    if (gnt !== 8'h01)
      $display("FAIL reset_grant_held: gnt=%h expected 01", gnt);
    else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0)
      $display("FAIL reset_async_clear: gnt=%h valid=%b expected 00/0", gnt, gnt_valid);
    else n_pass++;
    tick();
    rstn = 1'b1;
    n_total++;
    if (gnt_valid !== 1'b0)
      $display("FAIL reset_still_idle: valid=%b expected 0", gnt_valid);
    else n_pass++;
    tick();
    n_total++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1)
      $display("FAIL reset_regrant: gnt=%h idx=%0d valid=%b expected 01/0/1", gnt, gnt_idx, gnt_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int exp_i;
    do_reset();
    weight = 32'h0;
    req    = 8'hFF;
    ack    = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_i = k % 8;
      n_total++;
      if (gnt_idx !== 3'(exp_i) || gnt !== 8'(1 << exp_i) || gnt_valid !== 1'b1)
        $display("FAIL rr_order[%0d]: gnt=%h idx=%0d valid=%b expected idx %0d", k, gnt, gnt_idx, gnt_valid, exp_i);
      else n_pass++;
    end
    ack = 1'b0;
    req = 8'h00;
  endtask

  task automatic test_weighted();
    int exp_i;
    int cnt0;
    int cnt1;
    cnt0 = 0;
    cnt1 = 0;
    do_reset();
    weight = 32'h0000_0003;
    req    = 8'h03;
    ack    = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      exp_i = ((k % 5) == 4) ? 1 : 0;
      if (gnt == 8'h01) cnt0++;
      if (gnt == 8'h02) cnt1++;
      if (k < 10) begin
        n_total++;
        if (gnt_idx !== 3'(exp_i) || gnt_valid !== 1'b1)
          $display("FAIL wrr_pattern[%0d]: idx=%0d valid=%b expected idx %0d", k, gnt_idx, gnt_valid, exp_i);
        else n_pass++;
      end
    end
    n_total++;
    if (cnt0 !== 40)
      $display("FAIL wrr_share_port0: got %0d grants expected 40", cnt0);
    else n_pass++;
    n_total++;
    if (cnt1 !== 10)
      $display("FAIL wrr_share_port1: got %0d grants expected 10", cnt1);
    else n_pass++;
    ack = 1'b0;
    req = 8'h00;
  endtask

  task automatic test_hold();
    do_reset();
    weight = 32'h0;
    req    = 8'h24;
    ack    = 1'b0;
    tick();
    n_total++;
    if (gnt !== 8'h04)
      $display("FAIL hold_initial: gnt=%h expected 04", gnt);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) enable = 1'b0;
      tick();
      n_total++;
      if (gnt !== 8'h04 || gnt_valid !== 1'b1)
        $display("FAIL hold_stable[%0d]: gnt=%h valid=%b expected 04/1", k, gnt, gnt_valid);
      else n_pass++;
    end
    enable = 1'b1;
    ack    = 1'b1;
    tick();
    n_total++;
    if (gnt !== 8'h20)
      $display("FAIL hold_next_after_ack: gnt=%h expected 20", gnt);
    else n_pass++;
    ack = 1'b0;
    req = 8'h00;
  endtask

  task automatic test_withdraw();
    do_reset();
    weight = 32'h0;
    req    = 8'h08;
    ack    = 1'b0;
    tick();
    n_total++;
    if (gnt !== 8'h08)
      $display("FAIL withdraw_grant: gnt=%h expected 08", gnt);
    else n_pass++;
    req = 8'h00;
    tick();
    n_total++;
    if (gnt_valid !== 1'b0 || gnt !== 8'h00)
      $display("FAIL withdraw_release: gnt=%h valid=%b expected 00/0", gnt, gnt_valid);
    else n_pass++;
    // Port 3 still has its credit and the pointer is still 0, so it beats port 4.
    req = 8'h18;
    tick();
    n_total++;
    if (gnt !== 8'h08)
      $display("FAIL withdraw_credit_kept: gnt=%h expected 08", gnt);
    else n_pass++;
    ack = 1'b1;
    tick();
    n_total++;
    if (gnt !== 8'h10)
      $display("FAIL withdraw_then_port4: gnt=%h expected 10", gnt);
    else n_pass++;
    ack = 1'b0;
    req = 8'h00;
  endtask

  task automatic test_age();
    int exp_i;
    int n_steps;
`ifdef NASTI_WRR_AGE_EN
    n_steps = 10;
`else
    n_steps = 17;
`endif
    do_reset();
    weight = 32'h0000_000F;
    req    = 8'h03;
    ack    = 1'b1;
    for (int k = 0; k < n_steps; k++) begin
      tick();
`ifdef NASTI_WRR_AGE_EN
      exp_i = (k == 4 || k == 9) ? 1 : 0;
`else
      exp_i = (k == 16) ? 1 : 0;
`endif
      n_total++;
      if (gnt_idx !== 3'(exp_i) || gnt_valid !== 1'b1)
        $display("FAIL age_sequence[%0d]: idx=%0d valid=%b expected idx %0d", k, gnt_idx, gnt_valid, exp_i);
      else n_pass++;
    end
    ack = 1'b0;
    req = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn   = 1'b0;
    req    = 8'h00;
    weight = 32'h0;
    enable = 1'b1;
    ack    = 1'b0;
    test_reset();
    test_round_robin();
    test_weighted();
    test_hold();
    test_withdraw();
    test_age();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
